// File: rtl/morse_pkg.sv
// morse_pkg: shared symbol codes, state encoding and word constants for Morse playback
package morse_pkg;
  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_DOT = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_RSVD = 2'b10;
  localparam logic [2:0] SYMS_PER_WORD = 3'd5;
  localparam int UNIT_W = 8;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    LOAD  = 4'd2,
    MARK  = 4'd3,
    SGAP  = 4'd4,
    WGAP  = 4'd5
  } state_t;
  function automatic logic is_mark(input logic [1:0] s);
    return s == SYM_DOT || s == SYM_DASH;
  endfunction
endpackage

// File: rtl/morse_unit_timer.sv
// morse_unit_timer: loadable tick down-counter; expire flags the final counted tick
module morse_unit_timer
  import morse_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic [UNIT_W-1:0] units,
  input  logic              tick,
  output logic              expire
);
  logic [UNIT_W-1:0] remaining;
  // reload on state entry, then count down one per tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) remaining <= '0;
    else if (load) remaining <= units;
    else if (tick && remaining != '0) remaining <= remaining - 1'b1;
  end
  assign expire = tick && remaining == UNIT_W'(1);
endmodule

// File: rtl/morse_playback.sv
// morse_playback: replays a RAM-stored Morse message on an LED; MORSE_PLAYBACK_REPEAT_EN loops forever
module morse_playback
  import morse_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 10,
  parameter int DOT_UNITS  = 1,
  parameter int DASH_UNITS = 3,
  parameter int SYM_GAP    = 1,
  parameter int WORD_GAP   = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic              led,
  output logic [1:0]        symbol,
  output logic              busy,
  output logic              done
);
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] len;
  logic [2:0]        played;
  logic [1:0]        first_sym, next_sym;
  logic              more, tmr_load, tmr_tick, expire;
  logic [UNIT_W-1:0] tmr_units;

  function automatic logic [UNIT_W-1:0] mark_units(input logic [1:0] s);
    return s == SYM_DASH ? UNIT_W'(DASH_UNITS) : UNIT_W'(DOT_UNITS);
  endfunction

  // ticks only count while a mark or gap is being timed; FETCH/LOAD drop them
  assign tmr_tick = tick && (state == MARK || state == SGAP || state == WGAP);

  // timer reload: the duration of whichever timed state comes next
  always_comb begin
    first_sym = mem_q[DATA_W-1 -: 2];
    next_sym  = shreg[DATA_W-3 -: 2];
    more      = is_mark(next_sym) && played < SYMS_PER_WORD - 3'd1;
    tmr_load  = state == LOAD || ((state == MARK || state == SGAP) && expire);
    tmr_units = state == LOAD ? (is_mark(first_sym) ? mark_units(first_sym) : UNIT_W'(WORD_GAP)) :
                state == MARK ? (more ? UNIT_W'(SYM_GAP) : UNIT_W'(WORD_GAP)) :
                mark_units(next_sym);
  end

  morse_unit_timer u_timer (
    .clock (clock),
    .resetn(resetn),
    .load  (tmr_load),
    .units (tmr_units),
    .tick  (tmr_tick),
    .expire(expire)
  );

  // playback sequencer: every output is registered alongside the state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      shreg    <= '0;
      len      <= '0;
      played   <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      led      <= 1'b0;
      symbol   <= SYM_EMPTY;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      led      <= 1'b0;
      symbol   <= SYM_EMPTY;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len <= length;
          if (length == '0) done <= 1'b1;
          else begin
            state  <= FETCH;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg  <= mem_q;
          played <= '0;
          if (is_mark(first_sym)) begin
            state  <= MARK;
            led    <= 1'b1;
            symbol <= first_sym;
          end else state <= WGAP;
        end
        MARK: if (expire) begin
          led    <= 1'b0;
          symbol <= SYM_EMPTY;
          state  <= more ? SGAP : WGAP;
        end
        SGAP: if (expire) begin
          shreg  <= shreg << 2;
          played <= played + 3'd1;
          state  <= MARK;
          led    <= 1'b1;
          symbol <= next_sym;
        end
        WGAP: if (expire) begin
          if (mem_addr != len - ADDR_W'(1)) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            state    <= FETCH;
            mem_rd   <= 1'b1;
          end else begin
`ifdef MORSE_PLAYBACK_REPEAT_EN
            mem_addr <= '0;
            state    <= FETCH;
            mem_rd   <= 1'b1;
`else
            mem_addr <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/morse_playback.md
# morse_playback

Replays a stored Morse message as timed on/off pulses on a single LED output. It walks the message RAM from address 0 to `length-1`, issuing synchronous reads. Each 10-bit word is decoded into up to five 2-bit symbols, which are played as marks and gaps timed in `tick` units. It is the reader for the player-one input path: same RAM image, same symbol encoding, opposite direction. It sits between the message RAM and an LEDG/LEDR output.

## Interface
- `ADDR_W`, 4, RAM address width.
- `DATA_W`, 10, RAM word width (five 2-bit symbols).
- `DOT_UNITS`, 1, mark length of a dot, in ticks.
- `DASH_UNITS`, 3, mark length of a dash, in ticks.
- `SYM_GAP`, 1, gap between symbols, in ticks.
- `WORD_GAP`, 3, gap after every word, in ticks.

- `clock`  in  1  sole clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle unit strobe (rate-divider output).
- `start`  in  1  begin playback; honoured only in IDLE.
- `abort`  in  1  synchronous stop; priority over everything except reset.
- `length`  in  ADDR_W  number of words; latched on accepted `start`.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rd`  out  1  read strobe; `mem_q` is valid the following cycle.
- `mem_q`  in  DATA_W  RAM read data.
- `led`  out  1  Morse output, 1 = mark.
- `symbol`  out  2  symbol currently playing, 00 when not in MARK.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- Symbol encoding: 00 = empty/end, 01 = dot, 11 = dash, 10 = reserved (treated as 00).
- Symbol order: `[9:8]` first, `[1:0]` last. The first 00/10 symbol ends the word.
- States:
  - IDLE → FETCH on `start`. Latches `length`. If `length`==0, pulses `done` and stays in IDLE instead.
  - FETCH: `mem_rd`=1 at `mem_addr` → LOAD.
  - LOAD: captures `mem_q` into the shift register → MARK if the first symbol is non-empty, else WGAP.
  - MARK: `led`=1 for DOT_UNITS or DASH_UNITS ticks. Then → SGAP if the next symbol is non-empty and fewer than 5 symbols have been played, else → WGAP.
  - SGAP: `led`=0 for SYM_GAP ticks, shifts left by 2 → MARK.
  - WGAP: `led`=0 for WORD_GAP ticks. If `mem_addr`==length-1 → IDLE with `done`; else `mem_addr`+1 → FETCH.
- The tick counter clears on every state entry; a tick is counted only in MARK/SGAP/WGAP. Ticks arriving in FETCH/LOAD are dropped.
- `abort` in any state: next cycle is IDLE, `led`=0, `mem_addr`=0, no `done`.
- `start` while busy is ignored. `start` and `abort` in the same cycle: abort wins and the block stays in IDLE.
- `mem_addr` is ADDR_W bits and never wraps, because `length` ≤ 2^ADDR_W−1 words.

## Timing
- Reset values: state IDLE, `led`=0, `symbol`=00, `mem_addr`=0, `mem_rd`=0, `busy`=0, `done`=0.
- Accepted `start` at edge N: FETCH in N+1, LOAD in N+2, `led` high from N+3.
- Mark ends on the edge after its final counted tick; `led` falls in that same cycle.
- `done` is asserted in the first IDLE cycle after the final WGAP tick, for exactly one cycle.
- All outputs are registered.

## Configuration
- `MORSE_PLAYBACK_REPEAT_EN` defined: the final WGAP returns to FETCH with `mem_addr`=0. `done` never pulses, `busy` stays high, and only `abort` or reset stops playback.
- Not defined: single pass as described above.

## Structure
- `morse_pkg` holds:
  - `SYM_EMPTY`, `SYM_DOT`, `SYM_DASH`, `SYM_RSVD`.
  - The state encoding (4-bit localparams IDLE..WGAP).
  - The symbols-per-word constant `SYMS_PER_WORD`=5.
- Sub-module `morse_unit_timer`: loadable down-counter of ticks with `load`, `units`, and `tick` inputs and an `expire` output, shared by the MARK, SGAP and WGAP states.

## Test plan
All scenarios drive `tick` every 4 clocks.
- Reset mid-MARK: assert `resetn`=0 → all outputs return to reset values immediately (asynchronous); no `done`.
- Single word 10'b01_11_00_00_00, `length`=1, `start` → `led` high 1 tick, low 1 tick, high 3 ticks, low 3 ticks, then `done` pulse; `busy` falls in the same cycle.
- `length`=0, `start` → `done` pulses the next cycle and `mem_rd` never asserts.
- Two words, the first 10'b00_xx_xx_xx_xx → only WGAP (3 ticks low) for word 0, `mem_addr` reaches 1, then word 1 plays.
- Full word 10'b11_11_11_11_11 → five dashes with SGAP after the first four only; 3+1+3+1+3+1+3+1+3 ticks, then WGAP.
- `abort` during SGAP of word 2 → IDLE next cycle, `led`=0, `mem_addr`=0, no `done`. With `MORSE_PLAYBACK_REPEAT_EN`, `length`=2 → `mem_addr` sequence 0,1,0,1… and `done` never pulses.
